board_writer: RTL and testbench

Owns the 15x8 Tetris playfield and produces the current_board vector consumed by the LED display block; it is the writer side of that board interface. The game controller hands it a locked piece as up to four 8-bit row masks anchored at a row index. The block merges the piece into the board, detects full rows, collapses them with gravity, and reports the lines cleared and any collision through a valid/ready plus done handshake.

---
 rtl/board_writer_if.sv | 26 ++
 rtl/board_writer.sv | 111 +++++++++++
 tb/tb_board_writer.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/board_writer_if.sv
// Commit handshake and board view shared between the game controller (master)
// and the board writer (slave).
interface board_writer_if #(
    parameter int ROWS = 15,
    parameter int COLS = 8
);
    logic                       commit_valid;
    logic                       commit_ready;
    logic [3:0]                 commit_row;
    logic [3:0][COLS-1:0]       commit_mask;
    logic                       clear_board;
    logic [ROWS-1:0][COLS-1:0]  current_board;
    logic [2:0]                 lines_cleared;
    logic                       overlap;
    logic                       done;

    modport master (
        output commit_valid, commit_row, commit_mask, clear_board,
        input  commit_ready, current_board, lines_cleared, overlap, done
    );

    modport slave (
        input  commit_valid, commit_row, commit_mask, clear_board,
        output commit_ready, current_board, lines_cleared, overlap, done
    );
endinterface

// File: rtl/board_writer.sv
// Tetris playfield owner: merges a locked piece, then scans bottom-up and
// collapses full rows with gravity before reporting lines cleared and overlap.
module board_writer #(
    parameter int ROWS = 15,
    parameter int COLS = 8
) (
    input  logic        clk,
    input  logic        reset,
    board_writer_if.slave bus
);
    typedef enum logic [2:0] {IDLE, MERGE, SCAN, SHIFT, DONE} state_t;

    state_t                     state_q, state_d;
    logic [ROWS-1:0][COLS-1:0]  board_q, board_d;
    logic [3:0]                 row_q, row_d;
    logic [3:0][COLS-1:0]       mask_q, mask_d;
    logic [3:0]                 ptr_q, ptr_d;
    logic [2:0]                 cnt_q, cnt_d;
    logic                       ovl_q, ovl_d;
    logic [2:0]                 lines_q, lines_d;
    logic                       overlap_q, overlap_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            board_q   <= '0;
            row_q     <= '0;
            mask_q    <= '0;
            ptr_q     <= '0;
            cnt_q     <= '0;
            ovl_q     <= 1'b0;
            lines_q   <= '0;
            overlap_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            board_q   <= board_d;
            row_q     <= row_d;
            mask_q    <= mask_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            ovl_q     <= ovl_d;
            lines_q   <= lines_d;
            overlap_q <= overlap_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        board_d   = board_q;
        row_d     = row_q;
        mask_d    = mask_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        ovl_d     = ovl_q;
        lines_d   = lines_q;
        overlap_d = overlap_q;

        case (state_q)
            IDLE: begin
                if (bus.clear_board) begin
                    board_d = '0;
                end else if (bus.commit_valid) begin
                    row_d   = bus.commit_row;
                    mask_d  = bus.commit_mask;
                    state_d = MERGE;
                end
            end
            MERGE: begin
                // Row-major match keeps every index in range; mask rows past the bottom never hit.
                ovl_d = 1'b0;
                for (int r = 0; r < ROWS; r++) begin
                    for (int k = 0; k < 4; k++) begin
                        if (int'(row_q) + k == r) begin
                            ovl_d      = ovl_d | (|(board_q[r] & mask_q[k]));
                            board_d[r] = board_d[r] | mask_q[k];
                        end
                    end
                end
                ptr_d   = 4'(ROWS - 1);
                cnt_d   = '0;
                state_d = SCAN;
            end
            SCAN: begin
                if (board_q[ptr_q] == {COLS{1'b1}}) state_d = SHIFT;
                else if (ptr_q == 4'd0)             state_d = DONE;
                else                                ptr_d   = ptr_q - 4'd1;
            end
            SHIFT: begin
                // ptr stays put so the row dropped into it is rechecked.
                for (int r = 1; r < ROWS; r++) begin
                    if (r <= int'(ptr_q)) board_d[r] = board_q[r-1];
                end
                board_d[0] = '0;
                cnt_d      = (cnt_q == 3'd7) ? cnt_q : cnt_q + 3'd1;
                state_d    = SCAN;
            end
            DONE: begin
                lines_d   = cnt_q;
                overlap_d = ovl_q;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.commit_ready  = (state_q == IDLE) && !bus.clear_board;
    assign bus.current_board = board_q;
    assign bus.lines_cleared = lines_q;
    assign bus.overlap       = overlap_q;
    assign bus.done          = (state_q == DONE);
endmodule

// File: tb/tb_board_writer.sv
// Directed bench for board_writer: merge, line clears, overlap, wipe and abort.
module tb_board_writer;
    typedef logic [14:0][7:0] board_t;
    typedef logic [3:0][7:0]  mask_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    board_writer_if bif();

    board_writer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif)
    );

    // Commits one piece and returns the cycle (1 = MERGE) in which done was seen,
    // or 0 if it never came; leaves time 1 unit after the edge that closes DONE.
    task automatic commit(input logic [3:0] row, input mask_t mask, output int cyc);
        @(negedge clk);
        bif.commit_row   = row;
        bif.commit_mask  = mask;
        bif.commit_valid = 1'b1;
        @(posedge clk);
        #1 bif.commit_valid = 1'b0;
        cyc = 0;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            if (bif.done) begin
                cyc = c;
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wipe();
        @(negedge clk);
        bif.clear_board = 1'b1;
        @(posedge clk);
        #1 bif.clear_board = 1'b0;
    endtask

    task automatic test_reset();
        bif.commit_valid = 1'b0;
        bif.commit_row   = '0;
        bif.commit_mask  = '0;
        bif.clear_board  = 1'b0;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++; if (bif.current_board !== board_t'(0)) begin errors++; $display("FAIL reset_board got %h want 0", bif.current_board); end
        checks++; if (bif.commit_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", bif.commit_ready); end
        checks++; if (bif.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", bif.done); end
        checks++; if (bif.lines_cleared !== 3'd0) begin errors++; $display("FAIL reset_lines got %0d want 0", bif.lines_cleared); end
        checks++; if (bif.overlap !== 1'b0) begin errors++; $display("FAIL reset_overlap got %b want 0", bif.overlap); end
    endtask

    task automatic test_merge();
        int     cyc;
        board_t exp;
        exp = '0;
        exp[13] = 8'h18;
        exp[14] = 8'h18;
        commit(4'd13, {8'h00, 8'h00, 8'h18, 8'h18}, cyc);
        checks++; if (cyc !== 17) begin errors++; $display("FAIL merge_latency got %0d want 17", cyc); end
        checks++; if (bif.current_board !== exp) begin errors++; $display("FAIL merge_board got %h want %h", bif.current_board, exp); end
        checks++; if (bif.lines_cleared !== 3'd0) begin errors++; $display("FAIL merge_lines got %0d want 0", bif.lines_cleared); end
        checks++; if (bif.overlap !== 1'b0) begin errors++; $display("FAIL merge_overlap got %b want 0", bif.overlap); end
        checks++; if (bif.done !== 1'b0) begin errors++; $display("FAIL merge_done_pulse got %b want 0", bif.done); end
    endtask

    task automatic test_single_clear();
        int     cyc;
        board_t exp;
        wipe();
        commit(4'd14, {8'h00, 8'h00, 8'h00, 8'hF0}, cyc);
        exp = '0;
        exp[14] = 8'hF0;
        checks++; if (bif.current_board !== exp) begin errors++; $display("FAIL clear1_first_board got %h want %h", bif.current_board, exp); end
        commit(4'd14, {8'h00, 8'h00, 8'h00, 8'h0F}, cyc);
        checks++; if (cyc !== 19) begin errors++; $display("FAIL clear1_latency got %0d want 19", cyc); end
        checks++; if (bif.current_board !== board_t'(0)) begin errors++; $display("FAIL clear1_board got %h want 0", bif.current_board); end
        checks++; if (bif.lines_cleared !== 3'd1) begin errors++; $display("FAIL clear1_lines got %0d want 1", bif.lines_cleared); end
    endtask

    task automatic test_double_clear();
        int     cyc;
        board_t exp;
        wipe();
        commit(4'd12, {8'h00, 8'hFE, 8'hFE, 8'h81}, cyc);
        commit(4'd13, {8'h00, 8'h00, 8'h01, 8'h01}, cyc);
        exp = '0;
        exp[14] = 8'h81;
        checks++; if (cyc !== 21) begin errors++; $display("FAIL clear2_latency got %0d want 21", cyc); end
        checks++; if (bif.current_board !== exp) begin errors++; $display("FAIL clear2_board got %h want %h", bif.current_board, exp); end
        checks++; if (bif.lines_cleared !== 3'd2) begin errors++; $display("FAIL clear2_lines got %0d want 2", bif.lines_cleared); end
        checks++; if (bif.overlap !== 1'b0) begin errors++; $display("FAIL clear2_overlap got %b want 0", bif.overlap); end
    endtask

    task automatic test_overlap_and_range();
        int     cyc;
        board_t exp;
        wipe();
        commit(4'd14, {8'h00, 8'h00, 8'h00, 8'h3C}, cyc);
        commit(4'd14, {8'h00, 8'h00, 8'h00, 8'h18}, cyc);
        exp = '0;
        exp[14] = 8'h3C;
        checks++; if (bif.overlap !== 1'b1) begin errors++; $display("FAIL ovl_flag got %b want 1", bif.overlap); end
        checks++; if (bif.current_board !== exp) begin errors++; $display("FAIL ovl_board got %h want %h", bif.current_board, exp); end
        checks++; if (bif.lines_cleared !== 3'd0) begin errors++; $display("FAIL ovl_lines got %0d want 0", bif.lines_cleared); end
        commit(4'd15, {8'hFF, 8'hFF, 8'hFF, 8'hFF}, cyc);
        checks++; if (cyc !== 17) begin errors++; $display("FAIL range_latency got %0d want 17", cyc); end
        checks++; if (bif.current_board !== exp) begin errors++; $display("FAIL range_board got %h want %h", bif.current_board, exp); end
        checks++; if (bif.overlap !== 1'b0) begin errors++; $display("FAIL range_overlap got %b want 0", bif.overlap); end
    endtask

    task automatic test_wipe_and_abort();
        int     seen;
        board_t exp;
        // Wipe wins over a simultaneous commit; board row 14 still holds 3C here.
        @(negedge clk);
        bif.clear_board  = 1'b1;
        bif.commit_valid = 1'b1;
        bif.commit_row   = 4'd0;
        bif.commit_mask  = {8'hFF, 8'hFF, 8'hFF, 8'hFF};
        #1;
        checks++; if (bif.commit_ready !== 1'b0) begin errors++; $display("FAIL wipe_ready got %b want 0", bif.commit_ready); end
        @(posedge clk);
        #1;
        bif.clear_board  = 1'b0;
        bif.commit_valid = 1'b0;
        checks++; if (bif.current_board !== board_t'(0)) begin errors++; $display("FAIL wipe_board got %h want 0", bif.current_board); end
        seen = 0;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            if (bif.done) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL wipe_no_done got %0d pulses want 0", seen); end
        checks++; if (bif.current_board !== board_t'(0)) begin errors++; $display("FAIL wipe_no_merge got %h want 0", bif.current_board); end

        // Reset during SCAN aborts the commit.
        @(negedge clk);
        bif.commit_row   = 4'd5;
        bif.commit_mask  = {8'h00, 8'h00, 8'h00, 8'h01};
        bif.commit_valid = 1'b1;
        @(posedge clk);
        #1 bif.commit_valid = 1'b0;
        repeat (4) @(negedge clk);
        exp = '0;
        exp[5] = 8'h01;
        checks++; if (bif.current_board !== exp) begin errors++; $display("FAIL abort_premerge got %h want %h", bif.current_board, exp); end
        reset = 1'b0;
        #1;
        checks++; if (bif.current_board !== board_t'(0)) begin errors++; $display("FAIL abort_board got %h want 0", bif.current_board); end
        checks++; if (bif.done !== 1'b0) begin errors++; $display("FAIL abort_done got %b want 0", bif.done); end
        @(negedge clk);
        reset = 1'b1;
        seen = 0;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            if (bif.done) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL abort_no_done got %0d pulses want 0", seen); end
        checks++; if (bif.commit_ready !== 1'b1) begin errors++; $display("FAIL abort_ready got %b want 1", bif.commit_ready); end
    endtask

    initial begin
        test_reset();
        test_merge();
        test_single_clear();
        test_double_clear();
        test_overlap_and_range();
        test_wipe_and_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
